// File: rtl/regalu_pkg.sv
// Shared encodings for the register/ALU operation sequencer: request opcodes,
// FSM states and a small opcode-class helper.
package regalu_pkg;

    typedef enum logic [2:0] {
        OP_RR  = 3'd0,
        OP_RI  = 3'd1,
        OP_BEQ = 3'd2,
        OP_BNE = 3'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2,
        RESP = 2'd3
    } state_e;

    // Register-writing ops; branches and unknown codes skip write-back.
    function automatic logic op_is_alu(input logic [2:0] op);
        return (op == OP_RR) || (op == OP_RI);
    endfunction

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_RR) || (op == OP_RI) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/regalu_seq.sv
// Single-request sequencer driving register-file addresses and ALU controls.
// Optional completed-op counter enabled by defining REGALU_SEQ_PERF_EN.
//
//   state | meaning
//   IDLE  | ready for a new request
//   EXEC  | ALU evaluates latched operands, eq sampled on exit
//   WB    | register write-back (suppressed for rd == 0)
//   RESP  | response held until resp_ready
module regalu_seq
    import regalu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_op,
    input  logic [ADDRESS_WIDTH-1:0] req_rs1,
    input  logic [ADDRESS_WIDTH-1:0] req_rs2,
    input  logic [ADDRESS_WIDTH-1:0] req_rd,
    input  logic [2:0]               req_aluctrl,
    input  logic [DATA_WIDTH-1:0]    req_imm,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [ADDRESS_WIDTH-1:0] rd,
    output logic                     RegWrite,
    output logic                     ALUsrc,
    output logic [2:0]               ALUCtrl,
    output logic [DATA_WIDTH-1:0]    ImmOp,
    input  logic                     eq,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_taken,
    output logic                     resp_err,
    output logic [31:0]              op_count
);

    state_e                   state_q, state_d;
    logic [2:0]               op_q;
    logic [ADDRESS_WIDTH-1:0] rs1_q, rs2_q, rd_q;
    logic [2:0]               aluctrl_q;
    logic [DATA_WIDTH-1:0]    imm_q;
    logic                     taken_q, err_q;
    logic                     accept;
    logic                     resp_hs;

    assign accept  = req_valid && (state_q == IDLE);
    assign resp_hs = resp_ready && (state_q == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            aluctrl_q <= '0;
            imm_q     <= '0;
            taken_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q      <= req_op;
                rs1_q     <= req_rs1;
                rs2_q     <= req_rs2;
                rd_q      <= req_rd;
                aluctrl_q <= req_aluctrl;
                imm_q     <= req_imm;
            end
            // Branch outcome and error are frozen on the EXEC exit edge so the
            // response stays stable however long the consumer stalls.
            if (state_q == EXEC) begin
                taken_q <= ((op_q == OP_BEQ) && eq) || ((op_q == OP_BNE) && !eq);
                err_q   <= !op_is_legal(op_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid) state_d = EXEC;
            EXEC: state_d = op_is_alu(op_q) ? WB : RESP;
            WB:   state_d = RESP;
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decoded straight from the state register so reset drops RegWrite at once.
    always_comb begin
        req_ready  = (state_q == IDLE);
        RegWrite   = (state_q == WB) && (rd_q != '0);
        ALUsrc     = (op_q == OP_RI) && ((state_q == EXEC) || (state_q == WB));
        resp_valid = (state_q == RESP);
        resp_taken = (state_q == RESP) && taken_q;
        resp_err   = (state_q == RESP) && err_q;
    end

    assign rs1     = rs1_q;
    assign rs2     = rs2_q;
    assign rd      = rd_q;
    assign ALUCtrl = aluctrl_q;
    assign ImmOp   = imm_q;

`ifdef REGALU_SEQ_PERF_EN
    logic [31:0] op_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else if (resp_hs) begin
            op_count_q <= op_count_q + 32'd1;
        end
    end

    assign op_count = op_count_q;
`else
    assign op_count = '0;
`endif

endmodule

// File: doc/regalu_seq.md
REGALU_SEQ -- requirements
Module: regalu_seq

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning the datapath operand/immediate width.
REQ-002 The module SHALL have parameter ADDRESS_WIDTH, default 5, meaning the register address width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  1  operation request valid.
REQ-006 req_ready  output  1  sequencer can accept a request.
REQ-007 req_op  input  3  operation: OP_RR=0, OP_RI=1, OP_BEQ=2, OP_BNE=3, other codes illegal.
REQ-008 req_rs1, req_rs2, req_rd  input  ADDRESS_WIDTH each  register addresses.
REQ-009 req_aluctrl  input  3  ALU function code passed through to ALUCtrl.
REQ-010 req_imm  input  DATA_WIDTH  immediate operand.
REQ-011 rs1, rs2, rd  output  ADDRESS_WIDTH each  register-file addresses.
REQ-012 RegWrite  output  1  register-file write enable.
REQ-013 ALUsrc  output  1  0 selects register operand 2, 1 selects ImmOp.
REQ-014 ALUCtrl  output  3  ALU function.
REQ-015 ImmOp  output  DATA_WIDTH  immediate to the operand mux.
REQ-016 eq  input  1  ALU equality flag.
REQ-017 resp_valid  output  1  operation complete.
REQ-018 resp_ready  input  1  consumer accepts the response.
REQ-019 resp_taken  output  1  branch outcome, valid with resp_valid.
REQ-020 resp_err  output  1  illegal opcode, valid with resp_valid.
REQ-021 op_count  output  32  completed-operation counter (see Configuration).

Function
REQ-022 The FSM SHALL have states IDLE, EXEC, WB and RESP.
REQ-023 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-024 On accept, all req_* fields SHALL be latched, and the FSM SHALL go to EXEC; latched values SHALL drive rs1/rs2/rd/ALUCtrl/ImmOp unchanged until return to IDLE.
REQ-025 ALUsrc SHALL be 1 for OP_RI and 0 for all other ops.
REQ-026 EXEC SHALL last exactly one cycle; eq SHALL be sampled on the EXEC→next edge.
REQ-027 From EXEC, OP_RR/OP_RI SHALL go to WB, while branches and illegal ops SHALL go to RESP.
REQ-028 RegWrite SHALL be 1 only in WB, for exactly one cycle, and only if the latched rd≠0; WB SHALL always go to RESP.
REQ-029 In RESP, resp_valid SHALL be 1 and held with stable resp_taken/resp_err until resp_ready=1; that edge SHALL return the FSM to IDLE.
REQ-030 resp_taken SHALL equal sampled eq for OP_BEQ, ~eq for OP_BNE, and 0 otherwise.
REQ-031 resp_err SHALL be 1 for illegal opcodes; illegal ops SHALL never assert RegWrite.
REQ-032 ALU op latency SHALL be accept-edge to resp_valid = 2 cycles (EXEC, WB); for branches it SHALL be 1 cycle.
REQ-033 A request offered while not in IDLE SHALL be ignored; the requester holds it.
REQ-034 Back-to-back: resp_ready=1 in RESP and req_valid=1 the following cycle SHALL be accepted in that IDLE cycle (no extra bubble beyond IDLE).

Reset
REQ-035 rst_n=0 SHALL asynchronously force the state to IDLE; then RegWrite=0, resp_valid=0, resp_taken=0, resp_err=0, req_ready=1, op_count=0, and all latched fields/address/imm/ALUCtrl/ALUsrc outputs=0.
REQ-036 Reset during WB SHALL drop RegWrite immediately without waiting for a clock edge.

Configuration
REQ-037 With macro REGALU_SEQ_PERF_EN defined, op_count SHALL increment by 1 (wrapping at 2^32) on every RESP handshake.
REQ-038 Without REGALU_SEQ_PERF_EN, op_count SHALL be tied to 0 and no counter logic SHALL exist; the port list SHALL be unchanged.

Structure
REQ-039 Package regalu_pkg SHALL hold the op encoding enum (OP_RR..OP_BNE) and the FSM state enum.
REQ-040 No sub-module is required; the FSM and its output decode SHALL reside in regalu_seq.

Verification
REQ-041 Reset: assert rst_n=0 mid-WB → RegWrite falls asynchronously; after release req_ready=1 and op_count=0.
REQ-042 OP_RI: rs1=1, rd=3, imm=5, aluctrl=0 → ALUsrc=1 for 2 cycles, RegWrite=1 one cycle with rd=3, resp_valid 2 cycles after accept, resp_err=0.
REQ-043 OP_BEQ with eq=1 in EXEC → no RegWrite, resp_taken=1 one cycle after accept; OP_BNE with eq=1 → resp_taken=0.
REQ-044 OP_RR with rd=0 → RegWrite never asserts, resp_valid still asserts.
REQ-045 req_op=3'b111 → resp_err=1, RegWrite stays 0; resp_ready held 0 for 3 cycles → resp_valid and flags stable, req_ready=0 throughout.
REQ-046 PERF_EN build: 4 ops with immediate resp_ready=1 → op_count=4; non-PERF build → op_count=0.
